mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single data-memory port (pmem_read/pmem_write behind a valid/ready front end) between the IFU (read-only) and the LSU (read/write).
- Fixed LSU priority with an anti-starvation override for the IFU; one outstanding transaction at a time.
- Latches each accepted request and routes the response back to its owner.
- Sits between the IFU/LSU and the memory wrapper in the NPC core.

Parameters:
- AW, 64, address width
- DW, 64, data width
- MAX_WAIT, 4, consecutive IFU-blocked grant decisions before the IFU wins a contested arbitration (range 1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  AW  IFU read address
- ifu_resp_valid  out  1  IFU read data valid (1-cycle pulse)
- ifu_rdata  out  DW  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wen  in  1  1 = write, 0 = read
- lsu_addr  in  AW  LSU address
- lsu_wdata  in  DW  LSU write data
- lsu_wmask  in  8  LSU byte write mask
- lsu_resp_valid  out  1  LSU response (read data or write ack), 1-cycle pulse
- lsu_rdata  out  DW  LSU read data
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_wen  out  1  downstream write enable
- mem_addr  out  AW  downstream address
- mem_wdata  out  DW  downstream write data
- mem_wmask  out  8  downstream byte mask; 0 for reads
- mem_resp_valid  in  1  downstream response valid
- mem_rdata  in  DW  downstream read data

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE, owner = NONE, wait_cnt = 0.
  - All registered request fields are cleared.
  - All outputs are 0 on the following cycle.
  - Reset takes priority over every other event.
- FSM states: IDLE, REQ, WAIT.
- IDLE, grant decision (combinational):
  - Only lsu_req_valid set → LSU wins.
  - Only ifu_req_valid set → IFU wins.
  - Both set → IFU wins if wait_cnt == MAX_WAIT, otherwise LSU wins.
  - The winner's *_req_ready is 1 this cycle; the loser's is 0.
  - On a grant, latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0), set owner, go to REQ.
  - No request → stay in IDLE.
- wait_cnt:
  - +1, saturating at MAX_WAIT, on each IDLE grant to the LSU while ifu_req_valid = 1.
  - Cleared on any IFU grant.
  - Otherwise held.
- REQ:
  - mem_req_valid = 1; mem_* driven from latched fields only.
  - Fields are stable until mem_req_ready.
  - On mem_req_ready = 1, go to WAIT.
- WAIT:
  - mem_req_valid = 0.
  - On mem_resp_valid = 1:
    - Owner's *_resp_valid = 1 in the same cycle (combinational pass-through); the other is 0.
    - *_rdata = mem_rdata. For LSU writes, lsu_rdata is don't-care.
    - Go to IDLE. The next grant happens in the following cycle, never the same one.
- Latency:
  - Accept in cycle N; mem_req_valid in N+1.
  - With zero-wait memory (ready in N+1, response in N+2), the response reaches the requester in N+2.
  - The next accept is possible in N+3.
- Ignored inputs:
  - mem_resp_valid is ignored outside WAIT.
  - mem_req_ready is ignored outside REQ.
- *_req_ready is 0 in REQ and WAIT; requesters must hold their valid and payload until accepted.
- *_rdata is 0 whenever the matching *_resp_valid is 0.
- Reset mid-transaction (REQ or WAIT): the transaction is abandoned and no *_resp_valid is produced. The downstream memory wrapper shares rst.

Test Plan:
- Reset with both valids high → cycle after reset: all ready/resp/mem_req_valid = 0. The first post-reset cycle grants the LSU; wait_cnt becomes 1.
- IFU only, addr 0x8000_0000, zero-wait memory returning 0x0000_0013_0000_0297:
  - ifu_req_ready in cycle 0; mem_req_valid with mem_wen = 0, mem_wmask = 0 in cycle 1.
  - ifu_resp_valid with that rdata in cycle 2; lsu_resp_valid stays 0.
- LSU write, addr 0x8000_1004, wdata 0xDEAD_BEEF, wmask 0x0F, mem_req_ready delayed 3 cycles:
  - mem_* fields stable for all 4 REQ cycles.
  - lsu_resp_valid pulses once on mem_resp_valid.
- Both valid continuously, MAX_WAIT = 4:
  - Grant sequence is LSU, LSU, LSU, LSU, IFU, then repeats.
  - wait_cnt reads 0 after the IFU grant.
- Spurious events:
  - mem_resp_valid pulsed in IDLE and REQ → no *_resp_valid.
  - mem_req_ready pulsed in IDLE → state stays IDLE.
- rst asserted in WAIT for the LSU read, then mem_resp_valid:
  - No lsu_resp_valid; state = IDLE.
  - A subsequent IFU request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory port between the IFU (read) and LSU (read/write)
//            with LSU priority and an IFU anti-starvation override.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int AW       = 64,
    parameter int DW       = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_resp_valid,
    output logic [DW-1:0] ifu_rdata,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_wen,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_resp_valid,
    output logic [DW-1:0] lsu_rdata,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IFU = 2'd1, OWN_LSU = 2'd2} owner_t;

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    state_t        r_state_q,    w_state_d;
    owner_t        r_owner_q,    w_owner_d;
    logic [7:0]    r_wait_cnt_q, w_wait_cnt_d;
    logic [AW-1:0] r_addr_q,     w_addr_d;
    logic          r_wen_q,      w_wen_d;
    logic [DW-1:0] r_wdata_q,    w_wdata_d;
    logic [7:0]    r_wmask_q,    w_wmask_d;
    logic          w_grant_lsu;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= IDLE;
            r_owner_q    <= OWN_NONE;
            r_wait_cnt_q <= '0;
            r_addr_q     <= '0;
            r_wen_q      <= 1'b0;
            r_wdata_q    <= '0;
            r_wmask_q    <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_owner_q    <= w_owner_d;
            r_wait_cnt_q <= w_wait_cnt_d;
            r_addr_q     <= w_addr_d;
            r_wen_q      <= w_wen_d;
            r_wdata_q    <= w_wdata_d;
            r_wmask_q    <= w_wmask_d;
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_owner_d      = r_owner_q;
        w_wait_cnt_d   = r_wait_cnt_q;
        w_addr_d       = r_addr_q;
        w_wen_d        = r_wen_q;
        w_wdata_d      = r_wdata_q;
        w_wmask_d      = r_wmask_q;
        w_grant_lsu    = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        // Handshake outputs are suppressed while reset is held so nothing is granted or returned.
        if (!rst) begin
            case (r_state_q)
                IDLE: begin
                    w_grant_lsu = lsu_req_valid &&
                                  !(ifu_req_valid && (r_wait_cnt_q == c_max_wait));
                    if (w_grant_lsu) begin
                        lsu_req_ready = 1'b1;
                        w_addr_d      = lsu_addr;
                        w_wen_d       = lsu_wen;
                        w_wdata_d     = lsu_wdata;
                        w_wmask_d     = lsu_wen ? lsu_wmask : 8'h00;
                        w_owner_d     = OWN_LSU;
                        w_state_d     = REQ;
                        if (ifu_req_valid && (r_wait_cnt_q < c_max_wait)) begin
                            w_wait_cnt_d = r_wait_cnt_q + 8'd1;
                        end
                    end else if (ifu_req_valid) begin
                        ifu_req_ready = 1'b1;
                        w_addr_d      = ifu_addr;
                        w_wen_d       = 1'b0;
                        w_wdata_d     = '0;
                        w_wmask_d     = 8'h00;
                        w_owner_d     = OWN_IFU;
                        w_state_d     = REQ;
                        w_wait_cnt_d  = '0;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        w_state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (r_owner_q == OWN_IFU) begin
                            ifu_resp_valid = 1'b1;
                            ifu_rdata      = mem_rdata;
                        end else if (r_owner_q == OWN_LSU) begin
                            lsu_resp_valid = 1'b1;
                            lsu_rdata      = mem_rdata;
                        end
                        w_owner_d = OWN_NONE;
                        w_state_d = IDLE;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid = (r_state_q == REQ);
    assign mem_wen       = r_wen_q;
    assign mem_addr      = r_addr_q;
    assign mem_wdata     = r_wdata_q;
    assign mem_wmask     = r_wmask_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed, table-driven checks of mem_arbiter with a simple memory model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(64), .DW(64), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          ifu_v;
        bit          lsu_v;
        bit          wen;
        logic [63:0] ifu_a;
        logic [63:0] lsu_a;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          dly;
        logic [63:0] rdata;
        bit          exp_ifu;
        logic [63:0] exp_addr;
        bit          exp_wen;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wmask;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        cyc();
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
        ifu_req_valid = v.ifu_v; ifu_addr = v.ifu_a;
        lsu_req_valid = v.lsu_v; lsu_addr = v.lsu_a; lsu_wen = v.wen;
        lsu_wdata = v.wdata; lsu_wmask = v.wmask;
        #2;
        chk({tag, " ifu_req_ready"}, 64'(ifu_req_ready), 64'(v.exp_ifu));
        chk({tag, " lsu_req_ready"}, 64'(lsu_req_ready), 64'(!v.exp_ifu));
        cyc();
        ifu_req_valid = 0; lsu_req_valid = 0;
        mem_req_ready = (v.dly == 0);
        #2;
        chk({tag, " mem_req_valid"}, 64'(mem_req_valid), 64'd1);
        chk({tag, " mem_addr"}, mem_addr, v.exp_addr);
        chk({tag, " mem_wen"}, 64'(mem_wen), 64'(v.exp_wen));
        chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
        chk({tag, " mem_wmask"}, 64'(mem_wmask), 64'(v.exp_wmask));
        for (int i = 0; i < v.dly; i++) begin
            cyc();
            mem_req_ready = (i == v.dly - 1);
            #2;
            chk({tag, " held mem_req_valid"}, 64'(mem_req_valid), 64'd1);
            chk({tag, " held mem_addr"}, mem_addr, v.exp_addr);
            chk({tag, " held mem_wdata"}, mem_wdata, v.exp_wdata);
            chk({tag, " held mem_wmask"}, 64'(mem_wmask), 64'(v.exp_wmask));
        end
        cyc();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = v.rdata;
        #2;
        chk({tag, " wait mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, " ifu_resp_valid"}, 64'(ifu_resp_valid), 64'(v.exp_ifu));
        chk({tag, " lsu_resp_valid"}, 64'(lsu_resp_valid), 64'(!v.exp_ifu));
        if (v.exp_ifu) begin
            chk({tag, " ifu_rdata"}, ifu_rdata, v.rdata);
            chk({tag, " lsu_rdata idle"}, lsu_rdata, 64'd0);
        end else begin
            chk({tag, " ifu_rdata idle"}, ifu_rdata, 64'd0);
            if (!v.exp_wen) chk({tag, " lsu_rdata"}, lsu_rdata, v.rdata);
        end
        cyc();
        mem_resp_valid = 0; mem_rdata = '0;
        #2;
        chk({tag, " resp pulse ifu"}, 64'(ifu_resp_valid), 64'd0);
        chk({tag, " resp pulse lsu"}, 64'(lsu_resp_valid), 64'd0);
    endtask

    function automatic vec_t mk(bit iv, bit lv, bit w, logic [63:0] ia, logic [63:0] la,
                                logic [63:0] wd, logic [7:0] wm, int d, logic [63:0] rd,
                                bit ei, logic [63:0] ea, bit ew, logic [63:0] ewd,
                                logic [7:0] ewm);
        vec_t v;
        v.ifu_v = iv; v.lsu_v = lv; v.wen = w; v.ifu_a = ia; v.lsu_a = la;
        v.wdata = wd; v.wmask = wm; v.dly = d; v.rdata = rd; v.exp_ifu = ei;
        v.exp_addr = ea; v.exp_wen = ew; v.exp_wdata = ewd; v.exp_wmask = ewm;
        return v;
    endfunction

    initial begin
        // IFU-only fetch, then LSU write with a slow memory, then LSU read whose mask must be dropped.
        vecs[0] = mk(1, 0, 0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 0, 64'h0000_0013_0000_0297,
                     1, 64'h8000_0000, 0, 64'h0, 8'h00);
        vecs[1] = mk(0, 1, 1, 64'h0, 64'h8000_1004, 64'hDEAD_BEEF, 8'h0F, 3, 64'h0,
                     0, 64'h8000_1004, 1, 64'hDEAD_BEEF, 8'h0F);
        vecs[2] = mk(0, 1, 0, 64'h0, 64'h8000_2000, 64'h0, 8'hFF, 1, 64'h1122_3344_5566_7788,
                     0, 64'h8000_2000, 0, 64'h0, 8'h00);
        // Contested requests: four LSU wins fill the starvation counter, then the IFU wins.
        for (int i = 3; i < 7; i++)
            vecs[i] = mk(1, 1, 1, 64'h8000_0100, 64'h9000_0000 + 64'(i * 8), 64'(i), 8'hFF, 0,
                         64'h0, 0, 64'h9000_0000 + 64'(i * 8), 1, 64'(i), 8'hFF);
        vecs[7] = mk(1, 1, 1, 64'h8000_0100, 64'h9000_0040, 64'h7, 8'hFF, 0, 64'hCAFE_F00D,
                     1, 64'h8000_0100, 0, 64'h0, 8'h00);
        vecs[8] = mk(1, 1, 0, 64'h8000_0104, 64'h9000_0048, 64'h0, 8'h33, 0, 64'hABCD,
                     0, 64'h9000_0048, 0, 64'h0, 8'h00);

        clear_inputs();
        rst = 1;
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000;
        lsu_req_valid = 1; lsu_addr = 64'h8000_3000;
        cyc(); cyc();
        #2;
        chk("rst ifu_req_ready", 64'(ifu_req_ready), 64'd0);
        chk("rst lsu_req_ready", 64'(lsu_req_ready), 64'd0);
        chk("rst resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        chk("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst mem_addr", mem_addr, 64'd0);
        cyc();
        rst = 0;
        #2;
        chk("post-rst lsu_req_ready", 64'(lsu_req_ready), 64'd1);
        chk("post-rst ifu_req_ready", 64'(ifu_req_ready), 64'd0);
        cyc();
        ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
        #2;
        chk("post-rst mem_addr", mem_addr, 64'h8000_3000);
        cyc();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h55;
        #2;
        chk("post-rst lsu_rdata", lsu_rdata, 64'h55);

        for (int i = 0; i < 9; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Spurious memory handshakes outside the states that honour them.
        cyc();
        clear_inputs();
        mem_resp_valid = 1; mem_req_ready = 1; mem_rdata = 64'h77;
        #2;
        chk("idle spurious resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        chk("idle spurious rdata", ifu_rdata | lsu_rdata, 64'd0);
        cyc();
        mem_resp_valid = 0; mem_req_ready = 0;
        #2;
        chk("idle stays idle", 64'(mem_req_valid), 64'd0);
        cyc();
        lsu_req_valid = 1; lsu_addr = 64'h8000_4000;
        #2;
        chk("idle accepts lsu", 64'(lsu_req_ready), 64'd1);
        cyc();
        lsu_req_valid = 0; mem_resp_valid = 1; mem_rdata = 64'h99;
        #2;
        chk("req spurious resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        chk("req mem_req_valid", 64'(mem_req_valid), 64'd1);
        cyc();
        mem_resp_valid = 0; mem_req_ready = 1;
        #2;
        chk("req still pending", 64'(mem_req_valid), 64'd1);
        cyc();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h5;
        #2;
        chk("spurious-seq lsu_resp", 64'(lsu_resp_valid), 64'd1);
        chk("spurious-seq lsu_rdata", lsu_rdata, 64'h5);

        // Reset while waiting on a response abandons the transaction.
        cyc();
        clear_inputs();
        lsu_req_valid = 1; lsu_addr = 64'h8000_5000;
        #2;
        chk("abort accept", 64'(lsu_req_ready), 64'd1);
        cyc();
        lsu_req_valid = 0; mem_req_ready = 1;
        cyc();
        mem_req_ready = 0; rst = 1;
        cyc();
        rst = 0; mem_resp_valid = 1; mem_rdata = 64'hBAD;
        #2;
        chk("abort lsu_resp_valid", 64'(lsu_resp_valid), 64'd0);
        chk("abort lsu_rdata", lsu_rdata, 64'd0);
        chk("abort mem_req_valid", 64'(mem_req_valid), 64'd0);
        do_txn(mk(1, 0, 0, 64'h8000_0010, 64'h0, 64'h0, 8'h00, 0, 64'h1234_5678,
                  1, 64'h8000_0010, 0, 64'h0, 8'h00), "after-abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
